// File: rtl/proc_pkg.sv
// Shared processor definitions: register destination codes used by the
// register bank and the bus multiplexer.
package proc_pkg;

    localparam logic [3:0] SEL_RA = 4'b0000;
    localparam logic [3:0] SEL_RB = 4'b0001;
    localparam logic [3:0] SEL_RC = 4'b0010;
    localparam logic [3:0] SEL_R1 = 4'b0011;
    localparam logic [3:0] SEL_R2 = 4'b0100;
    localparam logic [3:0] SEL_R3 = 4'b0101;
    localparam logic [3:0] SEL_DR = 4'b0110;
    localparam logic [3:0] SEL_AC = 4'b1001;
    localparam logic [3:0] SEL_PC = 4'b1010;

    function automatic logic isValidSel(input logic [3:0] sel);
        logic ok;
        ok = 1'b0;
        case (sel)
            SEL_RA, SEL_RB, SEL_RC, SEL_R1, SEL_R2,
            SEL_R3, SEL_DR, SEL_AC, SEL_PC: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/bank_reg.sv
// Single WIDTH-bit storage register with load enable and a parameterised
// value applied by the asynchronous active-low reset.
module bank_reg #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= RESET_VAL;
        end else if (load_i) begin
            value_q <= d_i;
        end
    end

    assign q_o = value_q;

endmodule

// File: rtl/register_bank.sv
// Processor register bank: nine bus-loadable registers plus DR/AC/PC side
// controls. Optional AC zero flag enabled with macro REG_BANK_ZFLAG_EN.
module register_bank
    import proc_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [3:0]       load_sel,
    input  logic             load_en,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             dr_mem_load,
    input  logic             pc_inc,
    input  logic             ac_clr,
    output logic [WIDTH-1:0] DR,
    output logic [WIDTH-1:0] R1,
    output logic [WIDTH-1:0] R2,
    output logic [WIDTH-1:0] R3,
    output logic [WIDTH-1:0] RA,
    output logic [WIDTH-1:0] RB,
    output logic [WIDTH-1:0] RC,
    output logic [WIDTH-1:0] AC,
    output logic [WIDTH-1:0] PC,
`ifdef REG_BANK_ZFLAG_EN
    output logic             ac_zero,
`endif
    output logic             load_err
);

    localparam int NUM_SIMPLE = 6;
    localparam logic [3:0] SIMPLE_CODES [NUM_SIMPLE] =
        '{SEL_RA, SEL_RB, SEL_RC, SEL_R1, SEL_R2, SEL_R3};

    logic [WIDTH-1:0] simple_q [NUM_SIMPLE];

    // Registers with no side controls load only from the bus.
    for (genvar i = 0; i < NUM_SIMPLE; i++) begin : g_simple
        bank_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_reg (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (load_en && (load_sel == SIMPLE_CODES[i])),
            .d_i    (bus_in),
            .q_o    (simple_q[i])
        );
    end

    assign RA = simple_q[0];
    assign RB = simple_q[1];
    assign RC = simple_q[2];
    assign R1 = simple_q[3];
    assign R2 = simple_q[4];
    assign R3 = simple_q[5];

    logic             busDr;
    logic             busAc;
    logic             busPc;
    logic             dr_load;
    logic             ac_load;
    logic             pc_load;
    logic [WIDTH-1:0] dr_d;
    logic [WIDTH-1:0] ac_d;
    logic [WIDTH-1:0] pc_d;
    logic             load_err_d;
    logic             load_err_q;

    // Side controls win over the bus for DR and AC; a bus load wins over increment for PC.
    always_comb begin
        busDr      = load_en && (load_sel == SEL_DR);
        busAc      = load_en && (load_sel == SEL_AC);
        busPc      = load_en && (load_sel == SEL_PC);
        dr_load    = dr_mem_load || busDr;
        dr_d       = dr_mem_load ? mem_data : bus_in;
        ac_load    = ac_clr || busAc;
        ac_d       = ac_clr ? '0 : bus_in;
        pc_load    = busPc || pc_inc;
        pc_d       = busPc ? bus_in : PC + WIDTH'(1);
        load_err_d = load_en && !isValidSel(load_sel);
    end

    bank_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_dr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (dr_load),
        .d_i    (dr_d),
        .q_o    (DR)
    );

    bank_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ac (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ac_load),
        .d_i    (ac_d),
        .q_o    (AC)
    );

    bank_reg #(.WIDTH(WIDTH), .RESET_VAL(PC_RESET)) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (pc_load),
        .d_i    (pc_d),
        .q_o    (PC)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;

`ifdef REG_BANK_ZFLAG_EN
    logic [WIDTH-1:0] ac_next;
    logic             ac_zero_d;
    logic             ac_zero_q;

    // Flag tracks the value AC takes on this edge, so it never lags AC.
    always_comb begin
        ac_next   = ac_load ? ac_d : AC;
        ac_zero_d = (ac_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_zero_q <= 1'b1;
        end else begin
            ac_zero_q <= ac_zero_d;
        end
    end

    assign ac_zero = ac_zero_q;
`endif

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard testbench for register_bank; define REG_BANK_ZFLAG_EN to also
// check the AC zero flag.
module tb_register_bank;

    localparam int         W   = 16;
    localparam logic [W-1:0] PCR = 16'h0100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] bus_in = '0;
    logic [3:0]   load_sel = '0;
    logic         load_en = 1'b0;
    logic [W-1:0] mem_data = '0;
    logic         dr_mem_load = 1'b0;
    logic         pc_inc = 1'b0;
    logic         ac_clr = 1'b0;
    logic [W-1:0] DR, R1, R2, R3, RA, RB, RC, AC, PC;
    logic         load_err;
    logic         ac_zero;

    always #5 clk = ~clk;

    register_bank #(.WIDTH(W), .PC_RESET(PCR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_in      (bus_in),
        .load_sel    (load_sel),
        .load_en     (load_en),
        .mem_data    (mem_data),
        .dr_mem_load (dr_mem_load),
        .pc_inc      (pc_inc),
        .ac_clr      (ac_clr),
        .DR          (DR),
        .R1          (R1),
        .R2          (R2),
        .R3          (R3),
        .RA          (RA),
        .RB          (RB),
        .RC          (RC),
        .AC          (AC),
        .PC          (PC),
`ifdef REG_BANK_ZFLAG_EN
        .ac_zero     (ac_zero),
`endif
        .load_err    (load_err)
    );

`ifndef REG_BANK_ZFLAG_EN
    assign ac_zero = 1'b0;
`endif

    // Register index order: RA RB RC R1 R2 R3 DR AC PC
    typedef struct packed {
        logic [8:0][W-1:0] r;
        logic              err;
        logic              zf;
    } snap_t;

    snap_t        expQ[$];
    int           testsRun = 0;
    int           testsFailed = 0;
    logic [W-1:0] model [9];
    logic         modelErr;
    logic         modelZf;
    string        regName [9] = '{"RA", "RB", "RC", "R1", "R2", "R3", "DR", "AC", "PC"};

    function automatic snap_t observe();
        snap_t s;
        s.r[0] = RA; s.r[1] = RB; s.r[2] = RC;
        s.r[3] = R1; s.r[4] = R2; s.r[5] = R3;
        s.r[6] = DR; s.r[7] = AC; s.r[8] = PC;
        s.err  = load_err;
        s.zf   = ac_zero;
        return s;
    endfunction

    function automatic snap_t modelSnap();
        snap_t s;
        for (int i = 0; i < 9; i++) s.r[i] = model[i];
        s.err = modelErr;
        s.zf  = modelZf;
        return s;
    endfunction

    function automatic int codeToIdx(input logic [3:0] c);
        case (c)
            4'b0000: return 0;
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0011: return 3;
            4'b0100: return 4;
            4'b0101: return 5;
            4'b0110: return 6;
            4'b1001: return 7;
            4'b1010: return 8;
            default: return -1;
        endcase
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 9; i++) model[i] = '0;
        model[8] = PCR;
        modelErr = 1'b0;
        modelZf  = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input snap_t act, input snap_t exp);
        for (int i = 0; i < 9; i++) begin
            testsRun++;
            if (act.r[i] !== exp.r[i]) begin
                testsFailed++;
                $display("[TB] FAIL %s %s: got %h expected %h", tag, regName[i], act.r[i], exp.r[i]);
            end
        end
        testsRun++;
        if (act.err !== exp.err) begin
            testsFailed++;
            $display("[TB] FAIL %s load_err: got %b expected %b", tag, act.err, exp.err);
        end
`ifdef REG_BANK_ZFLAG_EN
        testsRun++;
        if (act.zf !== exp.zf) begin
            testsFailed++;
            $display("[TB] FAIL %s ac_zero: got %b expected %b", tag, act.zf, exp.zf);
        end
`endif
    endtask

    // Drives one cycle's controls now and queues the state expected after the next edge.
    task automatic driveAndModel(input logic [3:0] sel, input logic [W-1:0] bus, input logic en,
                                 input logic [W-1:0] mem, input logic drl, input logic inc,
                                 input logic clr);
        logic [W-1:0] nxt [9];
        int           idx;
        load_sel = sel; bus_in = bus; load_en = en;
        mem_data = mem; dr_mem_load = drl; pc_inc = inc; ac_clr = clr;
        nxt = model;
        idx = -1;
        modelErr = 1'b0;
        if (en) begin
            idx = codeToIdx(sel);
            if (idx < 0) modelErr = 1'b1;
            else         nxt[idx] = bus;
        end
        if (inc && idx != 8) nxt[8] = model[8] + 1'b1;
        if (clr) nxt[7] = '0;
        if (drl) nxt[6] = mem;
        modelZf = (nxt[7] == '0);
        model = nxt;
        expQ.push_back(modelSnap());
    endtask

    task automatic applyStimulus(input logic [3:0] sel, input logic [W-1:0] bus, input logic en,
                                 input logic [W-1:0] mem, input logic drl, input logic inc,
                                 input logic clr);
        @(negedge clk);
        driveAndModel(sel, bus, en, mem, drl, inc, clr);
    endtask

    task automatic applyIdle();
        applyStimulus(4'b0000, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic applyRandom();
        applyStimulus(4'($urandom_range(0, 15)), W'($urandom), 1'($urandom_range(0, 3) != 0),
                      W'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 5) == 0));
    endtask

    task automatic randomizeControls();
        load_sel = 4'($urandom); bus_in = W'($urandom); load_en = 1'b1;
        mem_data = W'($urandom); dr_mem_load = 1'b1; pc_inc = 1'b1; ac_clr = 1'b1;
    endtask

    // Reset lands mid-cycle and is checked before any clock edge arrives.
    task automatic doResetMidOp();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        randomizeControls();
        #1;
        resetModel();
        checkOutput("async_reset", observe(), modelSnap());
        expQ.push_back(modelSnap());
        @(negedge clk);
        randomizeControls();
        expQ.push_back(modelSnap());
        @(negedge clk);
        rst_n = 1'b1;
        driveAndModel(4'b0100, 16'hBEEF, 1'b1, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("cycle", observe(), e);
            end
        end
    end

    initial begin : stimulus
        int drainCycles;
        #2;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkOutput("power_on_reset", observe(), modelSnap());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        driveAndModel(4'b0000, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        applyStimulus(4'b0100, 16'h1234, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1111, 16'hDEAD, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        applyIdle();
        applyStimulus(4'b0111, 16'h7777, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1000, 16'h8888, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        applyIdle();

        applyStimulus(4'b1010, 16'hFFFF, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b1010, 16'h0040, 1'b1, '0, 1'b0, 1'b1, 1'b0);

        applyStimulus(4'b1001, 16'h1111, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1001, 16'h00FF, 1'b1, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0110, 16'h5555, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);

        applyStimulus(4'b1001, 16'h0001, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0011, 16'h3333, 1'b1, 16'h6666, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'b1100, 16'hCCCC, 1'b1, 16'h9999, 1'b1, 1'b1, 1'b0);

        repeat (300) applyRandom();
        doResetMidOp();
        repeat (200) applyRandom();

        @(negedge clk);
        load_en = 1'b0; dr_mem_load = 1'b0; pc_inc = 1'b0; ac_clr = 1'b0;
        drainCycles = 0;
        while (expQ.size() > 0 && drainCycles < 10) begin
            @(negedge clk);
            drainCycles++;
        end
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
